strand_fetch_scheduler: RTL and testbench

- Shares the single instruction-cache read port between STRANDS hardware strands.
- Each strand has its own instruction_fifo instance. This block:
  - picks one eligible strand per cycle, round-robin;
  - issues that strand's PC to the cache;
  - enqueues each hit into that strand's FIFO;
  - parks a strand on a miss until the fill completes;
  - applies per-strand rollbacks by flushing the FIFO and redirecting the PC.
- Sits between the strand FIFOs / rollback logic and the L1 instruction cache.

---
 rtl/strand_fetch_scheduler_pkg.sv | 21 ++
 rtl/strand_fetch_scheduler_rr_arbiter.sv | 28 ++
 rtl/strand_fetch_scheduler.sv | 116 +++++++++++
 tb/tb_strand_fetch_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strand_fetch_scheduler_pkg.sv
// Shared widths, FIFO entry layout and fetch stride for the strand fetch scheduler.
// The entry layout places the fetch PC above the instruction word.
package strand_fetch_scheduler_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int ENTRY_W = PC_W + INSTR_W;

    localparam logic [PC_W-1:0] FETCH_INCR = 32'd4;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fifo_entry_t;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [PC_W-1:0] next_fetch_pc(input logic [PC_W-1:0] pc);
        return pc + FETCH_INCR;
    endfunction

endpackage

// File: rtl/strand_fetch_scheduler_rr_arbiter.sv
// Round-robin grant: picks the first requester scanning upward from rr_ptr_i.
// N must equal 2**IDX_W so the index wraps by plain truncation.
module strand_fetch_scheduler_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     request_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_index_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant_valid_o = 1'b0;
        grant_index_o = '0;
        idx           = '0;
        for (int i = 0; i < N; i++) begin
            idx = rr_ptr_i + IDX_W'(i);
            if (!grant_valid_o && request_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_index_o = idx;
            end
        end
    end

endmodule

// File: rtl/strand_fetch_scheduler.sv
// Shares one instruction-cache read port among STRANDS strands: round-robin issue,
// hit enqueue, miss parking until fill, and per-strand rollback with FIFO flush.
module strand_fetch_scheduler
    import strand_fetch_scheduler_pkg::*;
#(
    parameter int              STRANDS     = 4,
    parameter int              STRAND_BITS = 2,
    parameter logic [PC_W-1:0] RESET_PC    = 32'h0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [STRANDS-1:0]         fifo_request_i,
    input  logic [STRANDS-1:0]         rollback_i,
    input  logic [PC_W*STRANDS-1:0]    rollback_pc_i,
    input  logic [STRANDS-1:0]         icache_load_complete_i,
    input  logic                       icache_hit_i,
    input  logic [INSTR_W-1:0]         icache_data_i,
    output logic                       icache_request_o,
    output logic [PC_W-1:0]            icache_addr_o,
    output logic [STRAND_BITS-1:0]     icache_strand_o,
    output logic [STRANDS-1:0]         fifo_enqueue_o,
    output logic [ENTRY_W-1:0]         fifo_value_o,
    output logic [STRANDS-1:0]         fifo_flush_o
);

    logic [STRANDS-1:0][PC_W-1:0] pc_q, pc_d;
    logic [STRANDS-1:0]           sleep_q, sleep_d;
    logic [STRANDS-1:0]           inflight_q, inflight_d;
    logic [STRAND_BITS-1:0]       rr_ptr_q, rr_ptr_d;

    // Registered response stage: which strand and PC the cache is answering this cycle.
    logic                         resp_valid_q;
    logic [STRAND_BITS-1:0]       resp_strand_q;
    logic [PC_W-1:0]              resp_pc_q;

    logic [STRANDS-1:0]           eligible;
    logic [STRANDS-1:0]           granted;
    logic [STRANDS-1:0]           resp_here;
    logic [STRANDS-1:0]           resp_hit;
    logic [STRANDS-1:0]           resp_miss;
    logic                         grant_valid;
    logic [STRAND_BITS-1:0]       grant_idx;
    logic                         issue;
    fifo_entry_t                  entry;

    strand_fetch_scheduler_rr_arbiter #(
        .N     (STRANDS),
        .IDX_W (STRAND_BITS)
    ) u_arb (
        .request_i     (eligible),
        .rr_ptr_i      (rr_ptr_q),
        .grant_valid_o (grant_valid),
        .grant_index_o (grant_idx)
    );

    // Outputs are forced quiet while reset is held, even with requests pending.
    assign issue = grant_valid & reset_n;

    for (genvar s = 0; s < STRANDS; s++) begin : g_strand
        assign eligible[s]  = fifo_request_i[s] & ~sleep_q[s] & ~inflight_q[s] & ~rollback_i[s];
        assign granted[s]   = issue && (grant_idx == STRAND_BITS'(s));
        assign resp_here[s] = resp_valid_q && (resp_strand_q == STRAND_BITS'(s));

        // A rollback in the response cycle discards the response entirely.
        assign resp_hit[s]  = resp_here[s] &  icache_hit_i & ~rollback_i[s];
        assign resp_miss[s] = resp_here[s] & ~icache_hit_i & ~rollback_i[s];

        assign pc_d[s] = rollback_i[s] ? rollback_pc_i[s*PC_W +: PC_W] :
                         resp_miss[s]  ? resp_pc_q :
                         granted[s]    ? next_fetch_pc(pc_q[s]) :
                                         pc_q[s];

        // A same-cycle load_complete belongs to an older fill, so the new miss wins.
        assign sleep_d[s] = rollback_i[s]             ? 1'b0 :
                            resp_miss[s]              ? 1'b1 :
                            icache_load_complete_i[s] ? 1'b0 :
                                                        sleep_q[s];

        assign inflight_d[s] = granted[s];
    end

    assign rr_ptr_d = issue ? grant_idx + STRAND_BITS'(1) : rr_ptr_q;

    assign icache_request_o = issue;
    assign icache_addr_o    = issue ? pc_q[grant_idx] : '0;
    assign icache_strand_o  = issue ? grant_idx : '0;

    assign entry.pc         = resp_pc_q;
    assign entry.instr      = icache_data_i;
    assign fifo_enqueue_o   = resp_hit;
    assign fifo_value_o     = (|resp_hit) ? entry : '0;
    assign fifo_flush_o     = rollback_i & {STRANDS{reset_n}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= {STRANDS{RESET_PC}};
            sleep_q       <= '0;
            inflight_q    <= '0;
            rr_ptr_q      <= '0;
            resp_valid_q  <= 1'b0;
            resp_strand_q <= '0;
            resp_pc_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            sleep_q       <= sleep_d;
            inflight_q    <= inflight_d;
            rr_ptr_q      <= rr_ptr_d;
            resp_valid_q  <= issue;
            if (issue) begin
                resp_strand_q <= grant_idx;
                resp_pc_q     <= pc_q[grant_idx];
            end
        end
    end

endmodule

// File: tb/tb_strand_fetch_scheduler.sv
// Directed bench for strand_fetch_scheduler: issue order, hit/miss/wake, rollback, PC wrap, reset.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_strand_fetch_scheduler;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   fifo_request_i;
    logic [3:0]   rollback_i;
    logic [127:0] rollback_pc_i;
    logic [3:0]   icache_load_complete_i;
    logic         icache_hit_i;
    logic [31:0]  icache_data_i;
    logic         icache_request_o;
    logic [31:0]  icache_addr_o;
    logic [1:0]   icache_strand_o;
    logic [3:0]   fifo_enqueue_o;
    logic [63:0]  fifo_value_o;
    logic [3:0]   fifo_flush_o;

    int checks = 0;
    int errors = 0;

    // Issue view {request, strand, addr}; enqueue view {enqueue, value}.
    logic [34:0]  exp_iss;
    logic [67:0]  exp_enq;
    logic [1:0]   rr_g    [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0]  rr_addr [5] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h104};

    strand_fetch_scheduler #(
        .STRANDS     (4),
        .STRAND_BITS (2),
        .RESET_PC    (32'h100)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .fifo_request_i         (fifo_request_i),
        .rollback_i             (rollback_i),
        .rollback_pc_i          (rollback_pc_i),
        .icache_load_complete_i (icache_load_complete_i),
        .icache_hit_i           (icache_hit_i),
        .icache_data_i          (icache_data_i),
        .icache_request_o       (icache_request_o),
        .icache_addr_o          (icache_addr_o),
        .icache_strand_o        (icache_strand_o),
        .fifo_enqueue_o         (fifo_enqueue_o),
        .fifo_value_o           (fifo_value_o),
        .fifo_flush_o           (fifo_flush_o)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] req, input logic [3:0] rb, input logic [3:0] lc,
                         input logic hit, input logic [31:0] data);
        @(negedge clk);
        fifo_request_i         = req;
        rollback_i             = rb;
        icache_load_complete_i = lc;
        icache_hit_i           = hit;
        icache_data_i          = data;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        fifo_request_i = '0; rollback_i = '0; icache_load_complete_i = '0;
        icache_hit_i = 1'b0; icache_data_i = '0; rollback_pc_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        fifo_request_i = 4'hF; rollback_i = 4'hF; icache_hit_i = 1'b1; icache_data_i = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({icache_request_o, icache_strand_o, icache_addr_o, fifo_enqueue_o, fifo_value_o, fifo_flush_o} !== 107'd0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b strand=%0d addr=%h enq=%b val=%h flush=%b, required all zero",
                     icache_request_o, icache_strand_o, icache_addr_o, fifo_enqueue_o, fifo_value_o, fifo_flush_o);
        end
    endtask

    task automatic test_single_strand();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(4'b0001, 4'b0, 4'b0, 1'b1, 32'hA0A0_A0A0);
            exp_iss = {1'b1, 2'd0, 32'h100 + 32'(4 * k)};
            checks++;
            if ({icache_request_o, icache_strand_o, icache_addr_o} !== exp_iss) begin
                errors++;
                $display("FAIL single_issue[%0d]: got %h, required %h", k,
                         {icache_request_o, icache_strand_o, icache_addr_o}, exp_iss);
            end
            drive(4'b0001, 4'b0, 4'b0, 1'b1, 32'hA0A0_A0A0);
            exp_enq = {4'b0001, 32'h100 + 32'(4 * k), 32'hA0A0_A0A0};
            checks++;
            if ({fifo_enqueue_o, fifo_value_o} !== exp_enq || icache_request_o !== 1'b0) begin
                errors++;
                $display("FAIL single_enqueue[%0d]: got enq=%b val=%h req=%b, required %h req=0", k,
                         fifo_enqueue_o, fifo_value_o, icache_request_o, exp_enq);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(4'hF, 4'b0, 4'b0, 1'b1, 32'hC000_0000 + 32'(k));
            exp_iss = {1'b1, rr_g[k], rr_addr[k]};
            checks++;
            if ({icache_request_o, icache_strand_o, icache_addr_o} !== exp_iss) begin
                errors++;
                $display("FAIL rr_issue[%0d]: got %h, required %h", k,
                         {icache_request_o, icache_strand_o, icache_addr_o}, exp_iss);
            end
            if (k > 0) begin
                exp_enq = {4'b0001 << rr_g[k-1], rr_addr[k-1], 32'hC000_0000 + 32'(k)};
                checks++;
                if ({fifo_enqueue_o, fifo_value_o} !== exp_enq) begin
                    errors++;
                    $display("FAIL rr_enqueue[%0d]: got %h, required %h", k,
                             {fifo_enqueue_o, fifo_value_o}, exp_enq);
                end
            end
        end
    endtask

    task automatic test_miss_wake();
        do_reset();
        rollback_pc_i[2*32 +: 32] = 32'h200;
        drive(4'b0000, 4'b0100, 4'b0, 1'b0, 32'h0);
        checks++;
        if (fifo_flush_o !== 4'b0100 || icache_request_o !== 1'b0) begin
            errors++;
            $display("FAIL miss_setup_flush: got flush=%b req=%b, required flush=0100 req=0", fifo_flush_o, icache_request_o);
        end
        drive(4'b0100, 4'b0, 4'b0, 1'b0, 32'h0);
        checks++;
        if ({icache_request_o, icache_strand_o, icache_addr_o} !== {1'b1, 2'd2, 32'h200}) begin
            errors++;
            $display("FAIL miss_first_issue: got %h, required %h",
                     {icache_request_o, icache_strand_o, icache_addr_o}, {1'b1, 2'd2, 32'h200});
        end
        drive(4'b0100, 4'b0, 4'b0, 1'b0, 32'h1111_1111);
        checks++;
        if (fifo_enqueue_o !== 4'b0 || icache_request_o !== 1'b0) begin
            errors++;
            $display("FAIL miss_no_enqueue: got enq=%b req=%b, required enq=0000 req=0", fifo_enqueue_o, icache_request_o);
        end
        for (int k = 0; k < 4; k++) begin
            drive(4'b0100, 4'b0, (k == 3) ? 4'b0100 : 4'b0, 1'b0, 32'h0);
            checks++;
            if (icache_request_o !== 1'b0) begin
                errors++;
                $display("FAIL miss_parked[%0d]: got req=%b addr=%h, required req=0", k, icache_request_o, icache_addr_o);
            end
        end
        drive(4'b0100, 4'b0, 4'b0, 1'b0, 32'h0);
        checks++;
        if ({icache_request_o, icache_strand_o, icache_addr_o} !== {1'b1, 2'd2, 32'h200}) begin
            errors++;
            $display("FAIL miss_reissue: got %h, required %h",
                     {icache_request_o, icache_strand_o, icache_addr_o}, {1'b1, 2'd2, 32'h200});
        end
        drive(4'b0000, 4'b0, 4'b0, 1'b1, 32'h0000_BEEF);
        checks++;
        if ({fifo_enqueue_o, fifo_value_o} !== {4'b0100, 32'h200, 32'h0000_BEEF}) begin
            errors++;
            $display("FAIL miss_refill_enqueue: got %h, required %h",
                     {fifo_enqueue_o, fifo_value_o}, {4'b0100, 32'h200, 32'h0000_BEEF});
        end
    endtask

    task automatic test_rollback_hit();
        do_reset();
        rollback_pc_i[1*32 +: 32] = 32'h40;
        drive(4'b0000, 4'b0010, 4'b0, 1'b0, 32'h0);
        drive(4'b0010, 4'b0, 4'b0, 1'b0, 32'h0);
        checks++;
        if ({icache_request_o, icache_strand_o, icache_addr_o} !== {1'b1, 2'd1, 32'h40}) begin
            errors++;
            $display("FAIL rb_first_issue: got %h, required %h",
                     {icache_request_o, icache_strand_o, icache_addr_o}, {1'b1, 2'd1, 32'h40});
        end
        rollback_pc_i[1*32 +: 32] = 32'h800;
        drive(4'b0010, 4'b0010, 4'b0, 1'b1, 32'h1234_5678);
        checks++;
        if (fifo_flush_o !== 4'b0010 || fifo_enqueue_o !== 4'b0 || icache_request_o !== 1'b0) begin
            errors++;
            $display("FAIL rb_drop_hit: got flush=%b enq=%b req=%b, required flush=0010 enq=0000 req=0",
                     fifo_flush_o, fifo_enqueue_o, icache_request_o);
        end
        drive(4'b0010, 4'b0, 4'b0, 1'b0, 32'h0);
        checks++;
        if ({icache_request_o, icache_strand_o, icache_addr_o} !== {1'b1, 2'd1, 32'h800}) begin
            errors++;
            $display("FAIL rb_redirect_issue: got %h, required %h",
                     {icache_request_o, icache_strand_o, icache_addr_o}, {1'b1, 2'd1, 32'h800});
        end
        drive(4'b0000, 4'b0, 4'b0, 1'b1, 32'h0000_CAFE);
        checks++;
        if ({fifo_enqueue_o, fifo_value_o, fifo_flush_o} !== {4'b0010, 32'h800, 32'h0000_CAFE, 4'b0}) begin
            errors++;
            $display("FAIL rb_redirect_enqueue: got %h, required %h",
                     {fifo_enqueue_o, fifo_value_o, fifo_flush_o}, {4'b0010, 32'h800, 32'h0000_CAFE, 4'b0});
        end
    endtask

    task automatic test_miss_stale_complete();
        do_reset();
        drive(4'b1000, 4'b0, 4'b0, 1'b0, 32'h0);
        checks++;
        if ({icache_request_o, icache_strand_o, icache_addr_o} !== {1'b1, 2'd3, 32'h100}) begin
            errors++;
            $display("FAIL stale_issue: got %h, required %h",
                     {icache_request_o, icache_strand_o, icache_addr_o}, {1'b1, 2'd3, 32'h100});
        end
        drive(4'b1000, 4'b0, 4'b1000, 1'b0, 32'h0);
        checks++;
        if (fifo_enqueue_o !== 4'b0 || icache_request_o !== 1'b0) begin
            errors++;
            $display("FAIL stale_miss: got enq=%b req=%b, required enq=0000 req=0", fifo_enqueue_o, icache_request_o);
        end
        for (int k = 0; k < 4; k++) begin
            drive(4'b1000, 4'b0, (k == 3) ? 4'b1000 : 4'b0, 1'b0, 32'h0);
            checks++;
            if (icache_request_o !== 1'b0) begin
                errors++;
                $display("FAIL stale_still_asleep[%0d]: got req=%b strand=%0d, required req=0", k, icache_request_o, icache_strand_o);
            end
        end
        drive(4'b1000, 4'b0, 4'b0, 1'b0, 32'h0);
        checks++;
        if ({icache_request_o, icache_strand_o, icache_addr_o} !== {1'b1, 2'd3, 32'h100}) begin
            errors++;
            $display("FAIL stale_wake_issue: got %h, required %h",
                     {icache_request_o, icache_strand_o, icache_addr_o}, {1'b1, 2'd3, 32'h100});
        end
        drive(4'b0000, 4'b0, 4'b0, 1'b1, 32'h0000_0055);
        checks++;
        if ({fifo_enqueue_o, fifo_value_o} !== {4'b1000, 32'h100, 32'h0000_0055}) begin
            errors++;
            $display("FAIL stale_wake_enqueue: got %h, required %h",
                     {fifo_enqueue_o, fifo_value_o}, {4'b1000, 32'h100, 32'h0000_0055});
        end
    endtask

    task automatic test_pc_wrap_and_reset();
        do_reset();
        rollback_pc_i[0 +: 32] = 32'hFFFF_FFFC;
        drive(4'b0000, 4'b0001, 4'b0, 1'b0, 32'h0);
        drive(4'b0001, 4'b0, 4'b0, 1'b0, 32'h0);
        checks++;
        if ({icache_request_o, icache_strand_o, icache_addr_o} !== {1'b1, 2'd0, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_issue_top: got %h, required %h",
                     {icache_request_o, icache_strand_o, icache_addr_o}, {1'b1, 2'd0, 32'hFFFF_FFFC});
        end
        drive(4'b0001, 4'b0, 4'b0, 1'b1, 32'h0000_0077);
        checks++;
        if ({fifo_enqueue_o, fifo_value_o} !== {4'b0001, 32'hFFFF_FFFC, 32'h0000_0077}) begin
            errors++;
            $display("FAIL wrap_enqueue: got %h, required %h",
                     {fifo_enqueue_o, fifo_value_o}, {4'b0001, 32'hFFFF_FFFC, 32'h0000_0077});
        end
        drive(4'b0001, 4'b0, 4'b0, 1'b0, 32'h0);
        checks++;
        if ({icache_request_o, icache_strand_o, icache_addr_o} !== {1'b1, 2'd0, 32'h0}) begin
            errors++;
            $display("FAIL wrap_issue_zero: got %h, required %h",
                     {icache_request_o, icache_strand_o, icache_addr_o}, {1'b1, 2'd0, 32'h0});
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        icache_hit_i = 1'b1;
        icache_data_i = 32'h0000_0099;
        #1;
        checks++;
        if ({icache_request_o, icache_strand_o, icache_addr_o, fifo_enqueue_o, fifo_value_o, fifo_flush_o} !== 107'd0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: got req=%b addr=%h enq=%b val=%h flush=%b, required all zero",
                     icache_request_o, icache_addr_o, fifo_enqueue_o, fifo_value_o, fifo_flush_o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        fifo_request_i = 4'b0;
        #1;
        checks++;
        if ({icache_request_o, fifo_enqueue_o, fifo_value_o} !== 69'd0) begin
            errors++;
            $display("FAIL post_reset_no_enqueue: got req=%b enq=%b val=%h, required all zero",
                     icache_request_o, fifo_enqueue_o, fifo_value_o);
        end
        drive(4'b0001, 4'b0, 4'b0, 1'b0, 32'h0);
        checks++;
        if ({icache_request_o, icache_strand_o, icache_addr_o} !== {1'b1, 2'd0, 32'h100}) begin
            errors++;
            $display("FAIL post_reset_pc: got %h, required %h",
                     {icache_request_o, icache_strand_o, icache_addr_o}, {1'b1, 2'd0, 32'h100});
        end
    endtask

    initial begin
        test_reset();
        test_single_strand();
        test_round_robin();
        test_miss_wake();
        test_rollback_hit();
        test_miss_stale_complete();
        test_pc_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
